// File: rtl/hazard_ctrl.sv
// Hazard detection, operand-forwarding selects and multiply/divide occupancy
// tracking for a five-stage MIPS pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr_FD,
    input  logic [31:0] Instr_DE,
    input  logic [31:0] Instr_EM,
    input  logic [31:0] Instr_MW,
    input  logic        RegWrite_DE,
    input  logic        RegWrite_EM,
    input  logic        RegWrite_MW,
    output logic        stall,
    output logic        forwardMD1,
    output logic        forwardMD2,
    output logic        forwardWD1,
    output logic        forwardWD2,
    output logic        forwardME1,
    output logic        forwardME2,
    output logic        forwardWE1,
    output logic        forwardWE2,
    output logic        forwardWM,
    output logic        mdu_busy,
    output logic [31:0] stall_cnt
);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] FN_ADDU    = 6'b100001;
    localparam logic [5:0] FN_SUBU    = 6'b100011;
    localparam logic [5:0] FN_JR      = 6'b001000;

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    function automatic logic is_alu_r(input logic [31:0] ins);
        return (ins[31:26] == OP_SPECIAL) && (ins[5:0] == FN_ADDU || ins[5:0] == FN_SUBU);
    endfunction

    function automatic logic is_alu_i(input logic [31:0] ins);
        return (ins[31:26] == OP_ORI) || (ins[31:26] == OP_LUI);
    endfunction

    function automatic logic is_lw(input logic [31:0] ins);
        return ins[31:26] == OP_LW;
    endfunction

    function automatic logic is_sw(input logic [31:0] ins);
        return ins[31:26] == OP_SW;
    endfunction

    function automatic logic is_beq(input logic [31:0] ins);
        return ins[31:26] == OP_BEQ;
    endfunction

    function automatic logic is_jr(input logic [31:0] ins);
        return (ins[31:26] == OP_SPECIAL) && (ins[5:0] == FN_JR);
    endfunction

    function automatic logic is_jal(input logic [31:0] ins);
        return ins[31:26] == OP_JAL;
    endfunction

    // mult/multu/div/divu share funct 0110xx; mfhi/mthi/mflo/mtlo share 0100xx.
    function automatic logic is_md_start(input logic [31:0] ins);
        return (ins[31:26] == OP_SPECIAL) && (ins[5:2] == 4'b0110);
    endfunction

    function automatic logic is_md_move(input logic [31:0] ins);
        return (ins[31:26] == OP_SPECIAL) && (ins[5:2] == 4'b0100);
    endfunction

    // A stage that does not write, or writes $0, reports dest 0 and never matches.
    function automatic logic [4:0] dest_of(input logic [31:0] ins, input logic we);
        logic [4:0] d;
        d = 5'd0;
        if (is_alu_r(ins))
            d = ins[15:11];
        else if (is_alu_i(ins) || is_lw(ins))
            d = ins[20:16];
        else if (is_jal(ins))
            d = 5'd31;
        return we ? d : 5'd0;
    endfunction

    logic [4:0]       dest_de, dest_em, dest_mw;
    logic [1:0]       tnew_de, tnew_em;
    logic [1:0][4:0]  src_fd, src_de;
    logic [1:0]       use_fd;
    logic [1:0][1:0]  tuse_fd;
    logic [1:0]       stall_src, fwd_md, fwd_wd, fwd_me, fwd_we;
    logic             data_stall, mdu_stall, md_start_de;

    logic [0:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [31:0]      stall_cnt_reg, stall_cnt_next;

    assign dest_de = dest_of(Instr_DE, RegWrite_DE);
    assign dest_em = dest_of(Instr_EM, RegWrite_EM);
    assign dest_mw = dest_of(Instr_MW, RegWrite_MW);
    assign tnew_de = is_lw(Instr_DE) ? 2'd2 : 2'd1;
    assign tnew_em = is_lw(Instr_EM) ? 2'd1 : 2'd0;

    always_comb begin
        src_fd[0] = Instr_FD[25:21];
        src_fd[1] = Instr_FD[20:16];
        src_de[0] = Instr_DE[25:21];
        src_de[1] = Instr_DE[20:16];
        use_fd    = 2'b00;
        tuse_fd   = '0;
        if (is_beq(Instr_FD)) begin
            use_fd = 2'b11;
        end else if (is_jr(Instr_FD)) begin
            use_fd = 2'b01;
        end else if (is_alu_r(Instr_FD)) begin
            use_fd     = 2'b11;
            tuse_fd[0] = 2'd1;
            tuse_fd[1] = 2'd1;
        end else if (is_alu_i(Instr_FD) || is_lw(Instr_FD)) begin
            use_fd     = 2'b01;
            tuse_fd[0] = 2'd1;
        end else if (is_sw(Instr_FD)) begin
            use_fd     = 2'b11;
            tuse_fd[0] = 2'd1;
            tuse_fd[1] = 2'd2;
        end
    end

    // Forward selects compare the raw rs/rt fields; an unused field only steers a dead mux.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign stall_src[gi] = use_fd[gi] &&
                ((dest_de != 5'd0 && dest_de == src_fd[gi] && tnew_de > tuse_fd[gi]) ||
                 (dest_em != 5'd0 && dest_em == src_fd[gi] && tnew_em > tuse_fd[gi]));
            assign fwd_md[gi] = (dest_em != 5'd0) && (dest_em == src_fd[gi]) &&
                                (tnew_em == 2'd0) && !stall;
            assign fwd_wd[gi] = (dest_mw != 5'd0) && (dest_mw == src_fd[gi]) && !fwd_md[gi];
            assign fwd_me[gi] = (dest_em != 5'd0) && (dest_em == src_de[gi]) &&
                                (tnew_em == 2'd0);
            assign fwd_we[gi] = (dest_mw != 5'd0) && (dest_mw == src_de[gi]) && !fwd_me[gi];
        end
    endgenerate

    assign md_start_de = is_md_start(Instr_DE);
    assign data_stall  = |stall_src;
    assign mdu_stall   = (is_md_start(Instr_FD) || is_md_move(Instr_FD)) &&
                         (mdu_busy || md_start_de);
    assign stall       = data_stall || mdu_stall;

    assign forwardMD1 = fwd_md[0];
    assign forwardMD2 = fwd_md[1];
    assign forwardWD1 = fwd_wd[0];
    assign forwardWD2 = fwd_wd[1];
    assign forwardME1 = fwd_me[0];
    assign forwardME2 = fwd_me[1];
    assign forwardWE1 = fwd_we[0];
    assign forwardWE2 = fwd_we[1];
    assign forwardWM  = is_sw(Instr_EM) && (dest_mw != 5'd0) && (Instr_EM[20:16] == dest_mw);

    assign mdu_busy  = (state_reg == ST_BUSY);
    assign stall_cnt = stall_cnt_reg;

    // A start seen while already busy is ignored: the FD stall keeps it from reaching DE.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        stall_cnt_next = stall_cnt_reg;
        if (stall && stall_cnt_reg != 32'hFFFF_FFFF)
            stall_cnt_next = stall_cnt_reg + 32'd1;
        case (state_reg)
            ST_IDLE: begin
                if (md_start_de) begin
                    state_next = ST_BUSY;
                    cnt_next   = Instr_DE[1] ? DIV_LOAD : MULT_LOAD;
                end
            end
            default: begin
                if (cnt_reg == CNT_ONE) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            stall_cnt_reg <= 32'd0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed pipeline scenarios followed by
// randomized stage contents, all checked against a table-driven reference model.
module tb_hazard_ctrl;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    localparam int K_NONE = 0, K_ALUR = 1, K_ALUI = 2, K_LW = 3, K_SW = 4, K_BEQ = 5,
                   K_JR = 6, K_JAL = 7, K_MULT = 8, K_DIV = 9, K_MDMOV = 10;

    logic        clk;
    logic        reset;
    logic [31:0] Instr_FD, Instr_DE, Instr_EM, Instr_MW;
    logic        RegWrite_DE, RegWrite_EM, RegWrite_MW;
    logic        stall, forwardMD1, forwardMD2, forwardWD1, forwardWD2;
    logic        forwardME1, forwardME2, forwardWE1, forwardWE2, forwardWM, mdu_busy;
    logic [31:0] stall_cnt;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_txn    = 0;
    int          m_busy_left = 0;
    logic [31:0] m_stall_cnt = 32'd0;

    hazard_ctrl #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .reset(reset),
        .Instr_FD(Instr_FD), .Instr_DE(Instr_DE), .Instr_EM(Instr_EM), .Instr_MW(Instr_MW),
        .RegWrite_DE(RegWrite_DE), .RegWrite_EM(RegWrite_EM), .RegWrite_MW(RegWrite_MW),
        .stall(stall), .forwardMD1(forwardMD1), .forwardMD2(forwardMD2),
        .forwardWD1(forwardWD1), .forwardWD2(forwardWD2),
        .forwardME1(forwardME1), .forwardME2(forwardME2),
        .forwardWE1(forwardWE1), .forwardWE2(forwardWE2),
        .forwardWM(forwardWM), .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic int kind_of(input logic [31:0] ins);
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        case (op)
            6'b000000: begin
                case (fn)
                    6'b100001, 6'b100011: return K_ALUR;
                    6'b001000: return K_JR;
                    6'b011000, 6'b011001: return K_MULT;
                    6'b011010, 6'b011011: return K_DIV;
                    6'b010000, 6'b010010, 6'b010001, 6'b010011: return K_MDMOV;
                    default: return K_NONE;
                endcase
            end
            6'b001101, 6'b001111: return K_ALUI;
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100: return K_BEQ;
            6'b000011: return K_JAL;
            default: return K_NONE;
        endcase
    endfunction

    function automatic int dest_m(input logic [31:0] ins, input logic we);
        int d;
        case (kind_of(ins))
            K_ALUR:       d = int'(ins[15:11]);
            K_ALUI, K_LW: d = int'(ins[20:16]);
            K_JAL:        d = 31;
            default:      d = 0;
        endcase
        return we ? d : 0;
    endfunction

    // Cycles until an operand must be ready; -1 marks an unused operand (0 = rs, 1 = rt).
    function automatic int tuse_m(input int k, input int idx);
        case (k)
            K_BEQ:        return 0;
            K_JR:         return (idx == 0) ? 0 : -1;
            K_ALUR:       return 1;
            K_ALUI, K_LW: return (idx == 0) ? 1 : -1;
            K_SW:         return (idx == 0) ? 1 : 2;
            default:      return -1;
        endcase
    endfunction

    function automatic logic [4:0] rnd_reg();
        int r;
        r = int'($urandom_range(0, 4));
        return (r == 4) ? 5'd31 : 5'(r);
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [5:0] fn;
        case ($urandom_range(0, 11))
            0:  return 32'd0;
            1:  return enc_r(rnd_reg(), rnd_reg(), rnd_reg(),
                             ($urandom_range(0, 1) == 0) ? 6'b100001 : 6'b100011);
            2:  return enc_i(6'b001101, rnd_reg(), rnd_reg(), 16'($urandom));
            3:  return enc_i(6'b001111, rnd_reg(), rnd_reg(), 16'($urandom));
            4:  return enc_i(6'b100011, rnd_reg(), rnd_reg(), 16'($urandom));
            5:  return enc_i(6'b101011, rnd_reg(), rnd_reg(), 16'($urandom));
            6:  return enc_i(6'b000100, rnd_reg(), rnd_reg(), 16'($urandom));
            7:  return enc_r(rnd_reg(), 5'd0, 5'd0, 6'b001000);
            8:  return {6'b000011, 26'($urandom)};
            9: begin
                fn = {4'b0110, 2'($urandom_range(0, 3))};
                return enc_r(rnd_reg(), rnd_reg(), 5'd0, fn);
            end
            10: begin
                fn = {4'b0100, 2'($urandom_range(0, 3))};
                return enc_r(rnd_reg(), 5'd0, rnd_reg(), fn);
            end
            default: return $urandom;
        endcase
    endfunction

    // Drive one cycle, check every output against the model, then advance the model by one edge.
    task automatic run_cycle(input logic [31:0] fd, input logic [31:0] de, input logic [31:0] em,
                             input logic [31:0] mw, input logic we_de, input logic we_em,
                             input logic we_mw, input logic rst_n);
        int  d_de, d_em, d_mw, k_fd, k_de, k_em, tn_de, tn_em, tu;
        int  s_fd[2];
        int  s_de[2];
        logic e_stall, e_wm;
        logic [1:0] e_md, e_wd, e_me, e_we;
        @(negedge clk);
        Instr_FD = fd; Instr_DE = de; Instr_EM = em; Instr_MW = mw;
        RegWrite_DE = we_de; RegWrite_EM = we_em; RegWrite_MW = we_mw;
        reset = rst_n;
        #1;
        k_fd = kind_of(fd); k_de = kind_of(de); k_em = kind_of(em);
        d_de = dest_m(de, we_de); d_em = dest_m(em, we_em); d_mw = dest_m(mw, we_mw);
        tn_de = (k_de == K_LW) ? 2 : 1;
        tn_em = (k_em == K_LW) ? 1 : 0;
        s_fd[0] = int'(fd[25:21]); s_fd[1] = int'(fd[20:16]);
        s_de[0] = int'(de[25:21]); s_de[1] = int'(de[20:16]);
        e_stall = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tu = tuse_m(k_fd, i);
            if (tu >= 0) begin
                if (d_de != 0 && d_de == s_fd[i] && tn_de > tu) e_stall = 1'b1;
                if (d_em != 0 && d_em == s_fd[i] && tn_em > tu) e_stall = 1'b1;
            end
        end
        if ((k_fd == K_MULT || k_fd == K_DIV || k_fd == K_MDMOV) &&
            (m_busy_left > 0 || k_de == K_MULT || k_de == K_DIV))
            e_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            e_md[i] = (d_em != 0 && s_fd[i] == d_em && tn_em == 0 && !e_stall);
            e_wd[i] = (d_mw != 0 && s_fd[i] == d_mw && !e_md[i]);
            e_me[i] = (d_em != 0 && s_de[i] == d_em && tn_em == 0);
            e_we[i] = (d_mw != 0 && s_de[i] == d_mw && !e_me[i]);
        end
        e_wm = (k_em == K_SW) && (d_mw != 0) && (int'(em[20:16]) == d_mw);

        check_eq("stall", 32'(stall), 32'(e_stall));
        check_eq("forwardMD1", 32'(forwardMD1), 32'(e_md[0]));
        check_eq("forwardMD2", 32'(forwardMD2), 32'(e_md[1]));
        check_eq("forwardWD1", 32'(forwardWD1), 32'(e_wd[0]));
        check_eq("forwardWD2", 32'(forwardWD2), 32'(e_wd[1]));
        check_eq("forwardME1", 32'(forwardME1), 32'(e_me[0]));
        check_eq("forwardME2", 32'(forwardME2), 32'(e_me[1]));
        check_eq("forwardWE1", 32'(forwardWE1), 32'(e_we[0]));
        check_eq("forwardWE2", 32'(forwardWE2), 32'(e_we[1]));
        check_eq("forwardWM", 32'(forwardWM), 32'(e_wm));
        check_eq("mdu_busy", 32'(mdu_busy), 32'(m_busy_left > 0));
        check_eq("stall_cnt", stall_cnt, m_stall_cnt);
        $display("txn %0d: FD=%08h DE=%08h EM=%08h MW=%08h rst=%b stall=%b busy=%b cnt=%0d",
                 n_txn, fd, de, em, mw, rst_n, stall, mdu_busy, stall_cnt);
        n_txn++;

        if (!rst_n) begin
            m_busy_left = 0;
            m_stall_cnt = 32'd0;
        end else begin
            if (e_stall && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt = m_stall_cnt + 32'd1;
            if (m_busy_left > 0)    m_busy_left = m_busy_left - 1;
            else if (k_de == K_MULT) m_busy_left = MULT_CYCLES;
            else if (k_de == K_DIV)  m_busy_left = DIV_CYCLES;
        end
    endtask

    initial begin : main
        logic [31:0] fd, de, em, mw, i_div, i_mflo;
        int busy_n, stall_n;
        reset = 1'b0;
        Instr_FD = 32'd0; Instr_DE = 32'd0; Instr_EM = 32'd0; Instr_MW = 32'd0;
        RegWrite_DE = 1'b0; RegWrite_EM = 1'b0; RegWrite_MW = 1'b0;
        i_div  = enc_r(5'd1, 5'd2, 5'd0, 6'b011010);
        i_mflo = enc_r(5'd0, 5'd0, 5'd3, 6'b010010);

        // Reset with nops in every stage.
        for (int c = 0; c < 2; c++) run_cycle(0, 0, 0, 0, 0, 0, 0, 1'b0);
        check_eq("reset_busy", 32'(mdu_busy), 32'd0);
        check_eq("reset_stall_cnt", stall_cnt, 32'd0);

        // Load-use: lw $8 in DE, addu $9,$8,$10 in FD.
        for (int c = 0; c < 3; c++) begin
            run_cycle(enc_r(5'd8, 5'd10, 5'd9, 6'b100001), enc_i(6'b100011, 5'd1, 5'd8, 16'd0),
                      0, 0, 1, 0, 0, 1'b1);
            check_eq("loaduse_stall", 32'(stall), 32'd1);
        end
        run_cycle(0, 0, 0, 0, 0, 0, 0, 1'b1);
        check_eq("loaduse_cnt", stall_cnt, 32'd3);

        // beq $8,$0 in FD fed by addu $8 in EM.
        run_cycle(enc_i(6'b000100, 5'd8, 5'd0, 16'd4), 0, enc_r(5'd1, 5'd2, 5'd8, 6'b100001),
                  0, 0, 1, 0, 1'b1);
        check_eq("beq_stall", 32'(stall), 32'd0);
        check_eq("beq_md1", 32'(forwardMD1), 32'd1);
        check_eq("beq_wd1", 32'(forwardWD1), 32'd0);

        // E-stage forwarding: EM priority over MW for both operands.
        run_cycle(0, enc_r(5'd5, 5'd5, 5'd6, 6'b100001), enc_i(6'b001101, 5'd0, 5'd5, 16'h1),
                  enc_i(6'b001111, 5'd0, 5'd5, 16'h2), 1, 1, 1, 1'b1);
        check_eq("e_me1", 32'(forwardME1), 32'd1);
        check_eq("e_me2", 32'(forwardME2), 32'd1);
        check_eq("e_we1", 32'(forwardWE1), 32'd0);
        check_eq("e_we2", 32'(forwardWE2), 32'd0);

        // Store data from a load in MW; then the same with a $0 destination.
        run_cycle(0, 0, enc_i(6'b101011, 5'd1, 5'd5, 16'd0), enc_i(6'b100011, 5'd2, 5'd5, 16'd0),
                  0, 0, 1, 1'b1);
        check_eq("sw_wm", 32'(forwardWM), 32'd1);
        check_eq("sw_stall", 32'(stall), 32'd0);
        run_cycle(0, 0, enc_i(6'b101011, 5'd1, 5'd0, 16'd0), enc_i(6'b100011, 5'd2, 5'd0, 16'd0),
                  0, 0, 1, 1'b1);
        check_eq("sw_zero_wm", 32'(forwardWM), 32'd0);
        check_eq("sw_zero_we2", 32'(forwardWE2), 32'd0);

        // div in DE with mflo waiting in FD.
        busy_n = 0;
        stall_n = 0;
        for (int c = 0; c < 13; c++) begin
            run_cycle(i_mflo, (c == 0) ? i_div : 32'd0, 0, 0, 0, 0, 0, 1'b1);
            busy_n  += int'(mdu_busy);
            stall_n += int'(stall);
        end
        check_eq("div_busy_cycles", 32'(busy_n), 32'd10);
        check_eq("div_stall_cycles", 32'(stall_n), 32'd11);

        // Reset during the fourth BUSY cycle aborts the divide.
        run_cycle(0, i_div, 0, 0, 0, 0, 0, 1'b1);
        for (int c = 0; c < 3; c++) run_cycle(i_mflo, 0, 0, 0, 0, 0, 0, 1'b1);
        check_eq("abort_busy_before", 32'(mdu_busy), 32'd1);
        run_cycle(i_mflo, 0, 0, 0, 0, 0, 0, 1'b0);
        run_cycle(i_mflo, 0, 0, 0, 0, 0, 0, 1'b1);
        check_eq("abort_busy", 32'(mdu_busy), 32'd0);
        check_eq("abort_stall", 32'(stall), 32'd0);
        check_eq("abort_cnt", stall_cnt, 32'd0);

        // Random stage contents; a start never enters DE while the unit is busy.
        for (int c = 0; c < 400; c++) begin
            fd = gen_instr();
            de = gen_instr();
            em = gen_instr();
            mw = gen_instr();
            if (m_busy_left > 0 && (kind_of(de) == K_MULT || kind_of(de) == K_DIV)) de = 32'd0;
            run_cycle(fd, de, em, mw, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 3) != 0, $urandom_range(0, 63) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
